// File: rtl/opl3_dac_mixer_if.sv
// Bundle between the OPL3 channel source (master) and the DAC mixer (slave).
// Carries channel samples and volume controls in, and mixed stereo samples and status out.
interface opl3_dac_mixer_if;
  logic               sample_clk_en;
  logic signed [15:0] channel_a;
  logic signed [15:0] channel_b;
  logic signed [15:0] channel_c;
  logic signed [15:0] channel_d;
  logic [8:0]         vol_target;
  logic               mute;
  logic               sample_valid;
  logic signed [23:0] left_channel;
  logic signed [23:0] right_channel;
  logic               overrun;
  logic [8:0]         vol_current;

  modport master (
    output sample_clk_en, channel_a, channel_b, channel_c, channel_d, vol_target, mute,
    input  sample_valid, left_channel, right_channel, overrun, vol_current
  );

  modport slave (
    input  sample_clk_en, channel_a, channel_b, channel_c, channel_d, vol_target, mute,
    output sample_valid, left_channel, right_channel, overrun, vol_current
  );
endinterface

// File: rtl/opl3_dac_mixer.sv
// Stereo OPL3 mixer: (A+C, B+D) x ramped volume through one shared multiplier, saturated to 24 bits.
// Define OPL3_DAC_DC_BLOCK_EN to add a per-channel first-order DC-blocking high-pass (DCF state).
module opl3_dac_mixer #(
  parameter int RAMP_STEP = 1
) (
  input logic             clk,
  input logic             reset,
  opl3_dac_mixer_if.slave bus
);
  localparam logic [8:0]         STEP    = 9'(RAMP_STEP);
  localparam logic [8:0]         VOL_MAX = 9'd256;
  localparam logic signed [25:0] SAT_MAX = 26'sd8388607;
  localparam logic signed [25:0] SAT_MIN = -26'sd8388608;

`ifdef OPL3_DAC_DC_BLOCK_EN
  typedef enum logic [2:0] {IDLE, MUL_L, MUL_R, DCF, OUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;
`endif

  state_t             state_q, state_d;
  logic signed [15:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [8:0]         vol_q, vol_d;
  logic signed [25:0] prod_l_q, prod_l_d;
  logic signed [23:0] left_q, left_d, right_q, right_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  function automatic logic signed [23:0] sat24(input logic signed [25:0] v);
    if (v > SAT_MAX) begin
      return 24'sh7FFFFF;
    end else if (v < SAT_MIN) begin
      return 24'sh800000;
    end else begin
      return v[23:0];
    end
  endfunction

`ifdef OPL3_DAC_DC_BLOCK_EN
  logic signed [23:0] x_l_q, x_l_d, x_r_q, x_r_d;
  logic signed [23:0] xp_l_q, xp_l_d, xp_r_q, xp_r_d;
  logic signed [25:0] y_l, y_r;

  // y_prev is the previous saturated output, which is exactly what left_q/right_q hold.
  function automatic logic signed [25:0] dc_step(input logic signed [23:0] x,
                                                 input logic signed [23:0] xp,
                                                 input logic signed [23:0] yp);
    logic signed [25:0] xe, xpe, ype;
    xe  = {{2{x[23]}}, x};
    xpe = {{2{xp[23]}}, xp};
    ype = {{2{yp[23]}}, yp};
    return xe - xpe + ype - (ype >>> 10);
  endfunction

  assign y_l = dc_step(x_l_q, xp_l_q, left_q);
  assign y_r = dc_step(x_r_q, xp_r_q, right_q);
`endif

  // Volume ramp toward the effective target, clamped so it lands exactly on it.
  logic [8:0] vol_tgt, vol_ramp;
  always_comb begin
    if (bus.mute) begin
      vol_tgt = '0;
    end else if (bus.vol_target > VOL_MAX) begin
      vol_tgt = VOL_MAX;
    end else begin
      vol_tgt = bus.vol_target;
    end
    vol_ramp = vol_q;
    if (vol_q < vol_tgt) begin
      vol_ramp = ((vol_tgt - vol_q) > STEP) ? vol_q + STEP : vol_tgt;
    end else if (vol_q > vol_tgt) begin
      vol_ramp = ((vol_q - vol_tgt) > STEP) ? vol_q - STEP : vol_tgt;
    end
  end

  // Shared multiplier: left sum in MUL_L, right sum in MUL_R.
  logic signed [16:0] sum_sel;
  logic signed [25:0] mul_a, mul_b, prod;
  always_comb begin
    if (state_q == MUL_L) begin
      sum_sel = {a_q[15], a_q} + {c_q[15], c_q};
    end else begin
      sum_sel = {b_q[15], b_q} + {d_q[15], d_q};
    end
    mul_a = {{9{sum_sel[16]}}, sum_sel};
    mul_b = {17'd0, vol_q};
    prod  = mul_a * mul_b;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    d_d       = d_q;
    vol_d     = vol_q;
    prod_l_d  = prod_l_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
`ifdef OPL3_DAC_DC_BLOCK_EN
    x_l_d     = x_l_q;
    x_r_d     = x_r_q;
    xp_l_d    = xp_l_q;
    xp_r_d    = xp_r_q;
`endif

    if (bus.sample_clk_en && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.sample_clk_en) begin
          a_d     = bus.channel_a;
          b_d     = bus.channel_b;
          c_d     = bus.channel_c;
          d_d     = bus.channel_d;
          vol_d   = vol_ramp;
          state_d = MUL_L;
        end
      end
      MUL_L: begin
        prod_l_d = prod;
        state_d  = MUL_R;
      end
      MUL_R: begin
`ifdef OPL3_DAC_DC_BLOCK_EN
        x_l_d   = sat24(prod_l_q);
        x_r_d   = sat24(prod);
        state_d = DCF;
`else
        left_d  = sat24(prod_l_q);
        right_d = sat24(prod);
        valid_d = 1'b1;
        state_d = OUT;
`endif
      end
`ifdef OPL3_DAC_DC_BLOCK_EN
      DCF: begin
        left_d  = sat24(y_l);
        right_d = sat24(y_r);
        xp_l_d  = x_l_q;
        xp_r_d  = x_r_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
`endif
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      vol_q     <= '0;
      prod_l_q  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef OPL3_DAC_DC_BLOCK_EN
      x_l_q     <= '0;
      x_r_q     <= '0;
      xp_l_q    <= '0;
      xp_r_q    <= '0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      d_q       <= d_d;
      vol_q     <= vol_d;
      prod_l_q  <= prod_l_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef OPL3_DAC_DC_BLOCK_EN
      x_l_q     <= x_l_d;
      x_r_q     <= x_r_d;
      xp_l_q    <= xp_l_d;
      xp_r_q    <= xp_r_d;
`endif
    end
  end

  assign bus.sample_valid  = valid_q;
  assign bus.left_channel  = left_q;
  assign bus.right_channel = right_q;
  assign bus.overrun       = overrun_q;
  assign bus.vol_current   = vol_q;
endmodule

// File: tb/tb_opl3_dac_mixer.sv
// Scoreboard bench for opl3_dac_mixer: a behavioural model pushes expected samples on each accepted
// strobe; the scenario tasks pop and compare when sample_valid appears.
module tb_opl3_dac_mixer;
`ifdef OPL3_DAC_DC_BLOCK_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int RAMP = 1;

  logic clk;
  logic reset;
  opl3_dac_mixer_if bus ();

  opl3_dac_mixer #(.RAMP_STEP(RAMP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int l;
    int r;
    int v;
  } exp_t;

  exp_t exp_q[$];
  int   vol_m, xpl, xpr, ypl, ypr;
  int   passed = 0;
  int   total  = 0;

  function automatic int sat24(input longint p);
    if (p > 64'sd8388607) return 8388607;
    if (p < -64'sd8388608) return -8388608;
    return int'(p);
  endfunction

  task automatic model_reset();
    vol_m = 0; xpl = 0; xpr = 0; ypl = 0; ypr = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input int a, input int b, input int c, input int d);
    int   tgt, yl, yr;
    exp_t e;
    tgt = bus.mute ? 0 : ((bus.vol_target > 9'd256) ? 256 : int'(bus.vol_target));
    if (vol_m < tgt) vol_m = (tgt - vol_m > RAMP) ? vol_m + RAMP : tgt;
    else if (vol_m > tgt) vol_m = (vol_m - tgt > RAMP) ? vol_m - RAMP : tgt;
    e.l = sat24(longint'(a + c) * vol_m);
    e.r = sat24(longint'(b + d) * vol_m);
    e.v = vol_m;
`ifdef OPL3_DAC_DC_BLOCK_EN
    yl = e.l - xpl + ypl - (ypl >>> 10);
    yr = e.r - xpr + ypr - (ypr >>> 10);
    xpl = e.l; xpr = e.r;
    ypl = sat24(longint'(yl)); ypr = sat24(longint'(yr));
    e.l = ypl; e.r = ypr;
`else
    yl = 0; yr = 0;
`endif
    exp_q.push_back(e);
  endtask

  // Drives one strobe, scrambles channels after capture, and collects what the DUT produced.
  task automatic run_sample(input int a, input int b, input int c, input int d,
                            output int gl, output int gr, output int gv,
                            output int lat, output int svn);
    @(posedge clk); #1;
    bus.channel_a = 16'(a);
    bus.channel_b = 16'(b);
    bus.channel_c = 16'(c);
    bus.channel_d = 16'(d);
    bus.sample_clk_en = 1'b1;
    model_push(a, b, c, d);
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
    bus.channel_a = 16'($urandom);
    bus.channel_b = 16'($urandom);
    bus.channel_c = 16'($urandom);
    bus.channel_d = 16'($urandom);
    gv = int'(bus.vol_current);
    lat = 99; gl = 0; gr = 0; svn = 1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.sample_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat != 99) begin
      gl = bus.left_channel;
      gr = bus.right_channel;
      @(negedge clk);
      svn = int'(bus.sample_valid);
    end
    $display("sample a=%0d b=%0d c=%0d d=%0d vol=%0d left=%0d right=%0d lat=%0d",
             a, b, c, d, gv, gl, gr, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.sample_valid);
    else passed++;
    total++;
    if (bus.left_channel !== 24'sd0 || bus.right_channel !== 24'sd0)
      $display("FAIL reset_outputs: got %0d/%0d want 0/0", bus.left_channel, bus.right_channel);
    else passed++;
    total++;
    if (bus.overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", bus.overrun);
    else passed++;
    total++;
    if (bus.vol_current !== 9'd0) $display("FAIL reset_vol: got %0d want 0", bus.vol_current);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (bus.sample_valid !== 1'b0 || bus.vol_current !== 9'd0)
      $display("FAIL reset_release: got valid=%b vol=%0d want 0/0", bus.sample_valid, bus.vol_current);
    else passed++;
  endtask

  task automatic test_ramp();
    int gl, gr, gv, lat, svn;
    exp_t e;
    bus.vol_target = 9'd256;
    bus.mute = 1'b0;
    for (int i = 0; i < 260; i++) begin
      run_sample(1000, 0, 0, 0, gl, gr, gv, lat, svn);
      e = exp_q.pop_front();
      total++;
      if (gl !== e.l || gr !== e.r || gv !== e.v || lat !== LAT || svn !== 0)
        $display("FAIL ramp[%0d]: got l=%0d r=%0d v=%0d lat=%0d sv_next=%0d want l=%0d r=%0d v=%0d lat=%0d sv_next=0",
                 i, gl, gr, gv, lat, svn, e.l, e.r, e.v, LAT);
      else passed++;
      if (i < 256) begin
        total++;
        if (gv !== i + 1) $display("FAIL ramp_count[%0d]: got %0d want %0d", i, gv, i + 1);
        else passed++;
      end
    end
    total++;
    if (gv !== 256) $display("FAIL ramp_hold: got %0d want 256", gv);
    else passed++;
`ifndef OPL3_DAC_DC_BLOCK_EN
    total++;
    if (gl !== 256000 || gr !== 0) $display("FAIL ramp_unity: got %0d/%0d want 256000/0", gl, gr);
    else passed++;
`endif
  endtask

  task automatic test_saturation();
    int gl, gr, gv, lat, svn;
    int va[3], vb[3], vc[3], vd[3], wl[3], wr[3];
    exp_t e;
    va = '{32767, 32767, -32768};
    vb = '{-32768, 0, 32767};
    vc = '{32767, 0, 0};
    vd = '{-32768, 0, 32767};
    wl = '{8388607, 8388352, -8388608};
    wr = '{-8388608, 0, 8388607};
    for (int i = 0; i < 3; i++) begin
      run_sample(va[i], vb[i], vc[i], vd[i], gl, gr, gv, lat, svn);
      e = exp_q.pop_front();
      total++;
      if (gl !== e.l || gr !== e.r || lat !== LAT)
        $display("FAIL sat_model[%0d]: got l=%0d r=%0d lat=%0d want l=%0d r=%0d lat=%0d",
                 i, gl, gr, lat, e.l, e.r, LAT);
      else passed++;
`ifndef OPL3_DAC_DC_BLOCK_EN
      total++;
      if (gl !== wl[i] || gr !== wr[i])
        $display("FAIL sat_const[%0d]: got %0d/%0d want %0d/%0d", i, gl, gr, wl[i], wr[i]);
      else passed++;
`endif
    end
  endtask

  task automatic test_clamp();
    int gl, gr, gv, lat, svn;
    exp_t e;
    bus.vol_target = 9'd400;
    for (int i = 0; i < 3; i++) begin
      run_sample(-1200, 700, 300, -50, gl, gr, gv, lat, svn);
      e = exp_q.pop_front();
      total++;
      if (gl !== e.l || gr !== e.r || gv !== 256 || lat !== LAT)
        $display("FAIL clamp[%0d]: got l=%0d r=%0d v=%0d lat=%0d want l=%0d r=%0d v=256 lat=%0d",
                 i, gl, gr, gv, lat, e.l, e.r, LAT);
      else passed++;
    end
    bus.vol_target = 9'd256;
  endtask

  task automatic test_mute();
    int gl, gr, gv, lat, svn;
    int phase_len[3], want_vol[3];
    exp_t e;
    phase_len = '{5, 3, 260};
    want_vol  = '{251, 254, 0};
    for (int p = 0; p < 3; p++) begin
      bus.mute = (p != 1);
      for (int i = 0; i < phase_len[p]; i++) begin
        run_sample(2000, -3000, 500, 0, gl, gr, gv, lat, svn);
        e = exp_q.pop_front();
        total++;
        if (gl !== e.l || gr !== e.r || gv !== e.v || lat !== LAT)
          $display("FAIL mute[%0d.%0d]: got l=%0d r=%0d v=%0d lat=%0d want l=%0d r=%0d v=%0d lat=%0d",
                   p, i, gl, gr, gv, lat, e.l, e.r, e.v, LAT);
        else passed++;
      end
      total++;
      if (gv !== want_vol[p]) $display("FAIL mute_vol[%0d]: got %0d want %0d", p, gv, want_vol[p]);
      else passed++;
    end
`ifndef OPL3_DAC_DC_BLOCK_EN
    total++;
    if (gl !== 0 || gr !== 0) $display("FAIL mute_silent: got %0d/%0d want 0/0", gl, gr);
    else passed++;
`endif
    bus.mute = 1'b0;
  endtask

  task automatic test_overrun();
    int   gaps[2];
    int   nvalid, first, gl, gr, gv, lat, svn;
    exp_t e;
    gaps = '{2, LAT};
    @(negedge clk);
    total++;
    if (bus.overrun !== 1'b0) $display("FAIL overrun_clean: got %b want 0", bus.overrun);
    else passed++;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus.channel_a = 16'(1000);
      bus.channel_b = -16'sd500;
      bus.channel_c = 16'(0);
      bus.channel_d = 16'(0);
      bus.sample_clk_en = 1'b1;
      model_push(1000, -500, 0, 0);
      @(posedge clk); #1;
      nvalid = 0; first = 99; gl = 0; gr = 0;
      for (int i = 1; i <= 12; i++) begin
        bus.sample_clk_en = (i == gaps[k]);
        @(negedge clk);
        if (bus.sample_valid === 1'b1) begin
          nvalid++;
          if (first == 99) begin
            first = i;
            gl = bus.left_channel;
            gr = bus.right_channel;
          end
        end
        @(posedge clk); #1;
      end
      bus.sample_clk_en = 1'b0;
      e = exp_q.pop_front();
      $display("overrun gap=%0d valids=%0d first=%0d left=%0d right=%0d overrun=%b",
               gaps[k], nvalid, first, gl, gr, bus.overrun);
      total++;
      if (nvalid !== 1 || first !== LAT)
        $display("FAIL overrun_single_valid[%0d]: got count=%0d lat=%0d want count=1 lat=%0d",
                 k, nvalid, first, LAT);
      else passed++;
      total++;
      if (gl !== e.l || gr !== e.r)
        $display("FAIL overrun_data[%0d]: got %0d/%0d want %0d/%0d", k, gl, gr, e.l, e.r);
      else passed++;
      total++;
      if (bus.overrun !== 1'b1) $display("FAIL overrun_flag[%0d]: got %b want 1", k, bus.overrun);
      else passed++;
    end
    run_sample(1000, 0, 0, 0, gl, gr, gv, lat, svn);
    e = exp_q.pop_front();
    total++;
    if (gl !== e.l || gv !== e.v || bus.overrun !== 1'b1)
      $display("FAIL overrun_sticky: got l=%0d v=%0d ovr=%b want l=%0d v=%0d ovr=1",
               gl, gv, bus.overrun, e.l, e.v);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    int nvalid;
    @(posedge clk); #1;
    bus.channel_a = 16'(2000);
    bus.channel_b = 16'(1500);
    bus.sample_clk_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sample_valid === 1'b1) nvalid++;
      @(posedge clk); #1;
      if (i == 2) reset = 1'b0;
    end
    model_reset();
    $display("reset_midflight valids=%0d left=%0d right=%0d vol=%0d overrun=%b",
             nvalid, bus.left_channel, bus.right_channel, bus.vol_current, bus.overrun);
    total++;
    if (nvalid !== 0) $display("FAIL midreset_valid: got %0d strobes want 0", nvalid);
    else passed++;
    total++;
    if (bus.left_channel !== 24'sd0 || bus.right_channel !== 24'sd0)
      $display("FAIL midreset_outputs: got %0d/%0d want 0/0", bus.left_channel, bus.right_channel);
    else passed++;
    total++;
    if (bus.vol_current !== 9'd0 || bus.overrun !== 1'b0)
      $display("FAIL midreset_state: got vol=%0d ovr=%b want 0/0", bus.vol_current, bus.overrun);
    else passed++;
  endtask

`ifdef OPL3_DAC_DC_BLOCK_EN
  task automatic test_dc_block();
    int   gl, gr, gv, lat, svn, prev;
    exp_t e;
    bus.vol_target = 9'd256;
    bus.mute = 1'b0;
    for (int i = 0; i < 256; i++) begin
      run_sample(0, 0, 0, 0, gl, gr, gv, lat, svn);
      e = exp_q.pop_front();
    end
    total++;
    if (gv !== 256 || gl !== 0) $display("FAIL dc_preramp: got v=%0d l=%0d want 256/0", gv, gl);
    else passed++;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      run_sample(4000, 0, 0, 0, gl, gr, gv, lat, svn);
      e = exp_q.pop_front();
      total++;
      if (gl !== e.l || gr !== e.r || lat !== 4)
        $display("FAIL dc_model[%0d]: got l=%0d r=%0d lat=%0d want l=%0d r=%0d lat=4",
                 i, gl, gr, lat, e.l, e.r);
      else passed++;
      total++;
      if (i == 0 ? (gl !== 1024000) : (gl >= prev || gl < 0))
        $display("FAIL dc_decay[%0d]: got %0d prev %0d", i, gl, prev);
      else passed++;
      prev = gl;
    end
  endtask
`endif

  initial begin
    bus.sample_clk_en = 1'b0;
    bus.channel_a = '0;
    bus.channel_b = '0;
    bus.channel_c = '0;
    bus.channel_d = '0;
    bus.vol_target = '0;
    bus.mute = 1'b0;
    reset = 1'b1;
    model_reset();
    test_reset();
    test_ramp();
    test_saturation();
    test_clamp();
    test_mute();
    test_overrun();
    test_reset_midflight();
`ifdef OPL3_DAC_DC_BLOCK_EN
    test_dc_block();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
